// File: rtl/sop_truth_sweeper.sv
// Sweeps all 16 input vectors through the SOP block and captures z1.
// Compares the captured truth table against a golden table.
module sop_truth_sweeper #(
    parameter int unsigned SETTLE   = 2,
    parameter logic [15:0] EXPECTED = 16'hFB8B
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        z1,
    output logic        x1,
    output logic        x2,
    output logic        x3,
    output logic        x4,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] truth,
    output logic [4:0]  mismatch_cnt,
    output logic [3:0]  first_fail
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] truth_q, truth_d;
    logic [4:0]  mcnt_q, mcnt_d;
    logic [3:0]  ff_q, ff_d;
    logic        pass_q, pass_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            truth_q <= '0;
            mcnt_q  <= '0;
            ff_q    <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            truth_q <= truth_d;
            mcnt_q  <= mcnt_d;
            ff_q    <= ff_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        truth_d = truth_q;
        mcnt_d  = mcnt_q;
        ff_d    = ff_q;
        pass_d  = pass_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SETTLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                    truth_d = '0;
                    mcnt_d  = '0;
                    ff_d    = '0;
                    pass_d  = 1'b0;
                end
            end
            S_SETTLE: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                truth_d[idx_q] = z1;
                if (z1 != EXPECTED[idx_q]) begin
                    mcnt_d = mcnt_q + 5'd1;
                    if (mcnt_q == 5'd0) begin
                        ff_d = idx_q;
                    end
                end
                if (idx_q == 4'd15) begin
                    state_d = S_DONE;
                    // Include the final sample so pass is already valid in DONE
                    pass_d  = (truth_d == EXPECTED);
                end else begin
                    state_d = S_SETTLE;
                    idx_d   = idx_q + 4'd1;
                    cnt_d   = '0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                pass_d  = (truth_q == EXPECTED);
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign {x1, x2, x3, x4} = idx_q;
    assign busy         = (state_q == S_SETTLE) || (state_q == S_SAMPLE);
    assign done         = (state_q == S_DONE);
    assign pass         = pass_q;
    assign truth        = truth_q;
    assign mismatch_cnt = mcnt_q;
    assign first_fail   = ff_q;

endmodule

// File: tb/tb_sop_truth_sweeper.sv
// Directed bench for sop_truth_sweeper with a selectable faulty SOP model.
// A second instance with SETTLE=1 drives a one-cycle registered SOP model.
module tb_sop_truth_sweeper;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        z1;
    logic        x1, x2, x3, x4;
    logic        busy, done, pass;
    logic [15:0] truth;
    logic [4:0]  mcnt;
    logic [3:0]  ff;

    logic        start_b = 1'b0;
    logic        z1_b = 1'b0;
    logic        xb1, xb2, xb3, xb4;
    logic        busy_b, done_b, pass_b;
    logic [15:0] truth_b;
    logic [4:0]  mcnt_b;
    logic [3:0]  ff_b;

    int mode = 0;
    int n_run = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    function automatic logic sop(input logic a, b, c, d);
        return (a & b) | (c & d) | (~b & ~c);
    endfunction

    always_comb begin
        case (mode)
            1:       z1 = 1'b0;
            2:       z1 = (x1 & x2) | (~x2 & ~x3);
            3:       z1 = ~sop(x1, x2, x3, x4);
            default: z1 = sop(x1, x2, x3, x4);
        endcase
    end

    always @(posedge clk) z1_b <= sop(xb1, xb2, xb3, xb4);

    sop_truth_sweeper #(.SETTLE(2), .EXPECTED(16'hFB8B)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .z1(z1),
        .x1(x1), .x2(x2), .x3(x3), .x4(x4),
        .busy(busy), .done(done), .pass(pass), .truth(truth),
        .mismatch_cnt(mcnt), .first_fail(ff)
    );

    sop_truth_sweeper #(.SETTLE(1), .EXPECTED(16'hFB8B)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .z1(z1_b),
        .x1(xb1), .x2(xb2), .x3(xb3), .x4(xb4),
        .busy(busy_b), .done(done_b), .pass(pass_b), .truth(truth_b),
        .mismatch_cnt(mcnt_b), .first_fail(ff_b)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic sweep(input string tag, input bit extra,
                         input logic [15:0] e_truth, input logic [4:0] e_mc,
                         input logic [3:0] e_ff, input logic e_pass);
        int nb = 0;
        int dcyc = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(negedge clk);
            if (cyc == 1) chk({tag, " x0"}, {28'd0, x1, x2, x3, x4}, 32'd0);
            if (busy) nb++;
            if (done) begin
                dcyc = cyc;
                break;
            end
            start = extra && (cyc == 5 || cyc == 30);
        end
        start = 1'b0;
        chk({tag, " busy_cycles"}, nb, 48);
        chk({tag, " done_cycle"}, dcyc, 49);
        @(negedge clk);
        chk({tag, " done_pulse"}, {31'd0, done}, 32'd0);
        chk({tag, " truth"}, {16'd0, truth}, {16'd0, e_truth});
        chk({tag, " pass"}, {31'd0, pass}, {31'd0, e_pass});
        chk({tag, " mcnt"}, {27'd0, mcnt}, {27'd0, e_mc});
        chk({tag, " first_fail"}, {28'd0, ff}, {28'd0, e_ff});
        chk({tag, " x_hold"}, {28'd0, x1, x2, x3, x4}, 32'hF);
        repeat (3) @(negedge clk);
        chk({tag, " hold"}, {truth, 3'd0, pass, mcnt, 3'd0, ff},
            {e_truth, 3'd0, e_pass, e_mc, 3'd0, e_ff});
    endtask

    initial begin
        int nb;
        int dcyc;
        bit hit;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst outs", {busy, done, pass, truth, mcnt, ff,
                         x1, x2, x3, x4}, 32'd0);

        // Abort a sweep at vector 7 with reset
        mode = 0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        hit = 0;
        for (int i = 0; i < 100; i++) begin
            if ({x1, x2, x3, x4} == 4'd7) begin
                hit = 1;
                break;
            end
            @(negedge clk);
        end
        chk("reach idx7", {31'd0, hit}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst outs", {busy, done, pass, truth, mcnt, ff,
                            x1, x2, x3, x4}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst held", {busy, truth, x1, x2, x3, x4}, 32'd0);

        sweep("golden", 0, 16'hFB8B, 5'd0, 4'd0, 1'b1);
        mode = 1;
        sweep("stuck0", 0, 16'h0000, 5'd11, 4'd0, 1'b0);
        mode = 2;
        sweep("no_x3x4", 0, 16'hF303, 5'd3, 4'd3, 1'b0);
        mode = 3;
        sweep("invert", 0, 16'h0474, 5'd16, 4'd0, 1'b0);
        mode = 0;
        sweep("start_busy", 1, 16'hFB8B, 5'd0, 4'd0, 1'b1);

        // SETTLE=1 against a registered SOP model
        nb = 0;
        dcyc = 0;
        @(negedge clk);
        start_b = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(negedge clk);
            start_b = 1'b0;
            if (busy_b) nb++;
            if (done_b) begin
                dcyc = cyc;
                break;
            end
        end
        chk("s1 busy_cycles", nb, 32);
        chk("s1 done_cycle", dcyc, 33);
        @(negedge clk);
        chk("s1 truth", {16'd0, truth_b}, 32'hFB8B);
        chk("s1 pass", {31'd0, pass_b}, 32'd1);
        chk("s1 mcnt", {27'd0, mcnt_b}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/sop_truth_sweeper.md
# sop_truth_sweeper

Self-checking stimulus/capture stage for the 4-input sum-of-products block (z1 = x1·x2 + x3·x4 + ~x2·~x3). On a start pulse it drives x1..x4 through all 16 combinations and waits a settle interval per vector. It then samples z1 into a 16-bit truth-table register and compares each sample against an expected table. It sits directly upstream of the SOP block, which consumes x1..x4, and directly downstream of it, capturing z1. Results go to board LEDs/switch logic.

## Interface
- SETTLE, 2, cycles each vector is held before z1 is sampled; legal 1..15
- EXPECTED, 16'hFB8B, golden truth table; bit i = z1 for vector i = {x1,x2,x3,x4}, x1 is the MSB
- clk  input  1  single clock; all state changes on the rising edge
- rst_n  input  1  reset, synchronous, active-low
- start  input  1  begin a sweep; sampled only in IDLE
- z1  input  1  output of the SOP block under test
- x1, x2, x3, x4  output  1 each  registered stimulus to the SOP block
- busy  output  1  high while a sweep is in progress
- done  output  1  one-cycle pulse when results are valid
- pass  output  1  1 = truth == EXPECTED; valid from done until the next start
- truth  output  16  captured z1 per vector
- mismatch_cnt  output  5  number of vectors where z1 != EXPECTED[i]; range 0..16
- first_fail  output  4  lowest failing vector index; meaningful only when pass=0, otherwise 0

## Operation
- FSM states and transitions:
  - IDLE: start=1 -> SETTLE, with idx=0, cnt=0, and truth, mismatch_cnt, first_fail, pass all cleared.
  - SETTLE: cnt increments each cycle; when cnt==SETTLE-1 -> SAMPLE.
  - SAMPLE: truth[idx] <= z1; on mismatch, mismatch_cnt++ and first_fail is latched if this is the first failure; if idx==15 -> DONE, else idx++, cnt=0 -> SETTLE.
  - DONE: done=1 and pass <= (final truth == EXPECTED) -> IDLE.
- {x1,x2,x3,x4} = idx (4 bits).
  - It changes only on SAMPLE -> SETTLE transitions.
  - It holds its last value (1111) after the sweep.
  - It returns to 0000 only on reset or start.
- The pass comparison uses the fully updated truth, so the vector-15 sample is included.
- start in SETTLE, SAMPLE or DONE is ignored; no queuing.
- Results (truth, pass, mismatch_cnt, first_fail) hold after DONE until the next accepted start.
- mismatch_cnt is 5 bits wide, so it cannot overflow; 16 is the maximum.

## Timing
- Reset (rst_n=0 at an edge): next cycle state=IDLE, x1..x4=0, busy=0, done=0, pass=0, truth=0, mismatch_cnt=0, first_fail=0, idx=0, cnt=0.
- Reset mid-sweep aborts immediately with the same values; no partial results are kept.
- start accepted at edge E0:
  - busy=1 from the cycle after E0, with x=0000 driven in that same cycle.
  - Each vector occupies SETTLE+1 cycles: SETTLE settle cycles, then 1 sample cycle.
  - z1 is sampled at the edge ending the SAMPLE cycle, so the SOP path has at least SETTLE+1 cycles to settle.
  - The last sample occurs at edge E0 + 16·(SETTLE+1).
  - The DONE cycle follows: done=1, busy=0.
  - IDLE is reached one edge later.
- With SETTLE=2: 48 busy cycles, done in cycle 49 after E0.
- Back-to-back sweeps: start held high through DONE is accepted in the first IDLE cycle.

## Test plan
- Reset: assert rst_n=0 for 2 cycles mid-sweep, idx=7 -> all outputs 0 next cycle; a subsequent start runs a full 16-vector sweep from 0000.
- Golden: SOP model connected, SETTLE=2, pulse start -> busy for 48 cycles, done pulse in cycle 49, truth=16'hFB8B, pass=1, mismatch_cnt=0, first_fail=0.
- Stuck-at-0: z1 tied 0 -> truth=16'h0000, pass=0, mismatch_cnt=11, first_fail=0.
- Missing x3·x4 term: z1 = x1·x2 + ~x2·~x3 -> truth=16'hF303, pass=0, mismatch_cnt=3, first_fail=3.
- Inverted output: z1 = ~SOP -> truth=16'h0474, mismatch_cnt=16, first_fail=0.
- Start while busy: extra start pulses at cycles 5 and 30 -> ignored; done still in cycle 49 and results unchanged.
- Settle bound: SETTLE=1 with a 1-cycle registered SOP model -> pass=1, 32 busy cycles.
